// File: rtl/simple_processor_pkg.sv
// Shared processor types: data width, execution function codes, LSU state.
package simple_processor_pkg;

  localparam int DATA_WIDTH          = 32;
  localparam int LSU_TIMEOUT_DEFAULT = 16;

  typedef enum logic [2:0] {
    ADD,
    SUB,
    SLL,
    SLT,
    LOAD,
    STORE,
    BRANCH,
    JUMP
  } func_t;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_WAIT,
    LSU_RESP
  } lsu_state_t;

endpackage

// File: rtl/dmem_lsu_ctrl_if.sv
// DMEM request/ack bus between the LSU controller (master) and data memory.
interface dmem_lsu_ctrl_if;
  import simple_processor_pkg::*;

  logic                  dmem_req_o;
  logic [DATA_WIDTH-1:0] dmem_addr_o;
  logic                  dmem_we_o;
  logic [DATA_WIDTH-1:0] dmem_wdata_o;
  logic [DATA_WIDTH-1:0] dmem_rdata_i;
  logic                  dmem_ack_i;

  modport master (
    output dmem_req_o, dmem_addr_o, dmem_we_o, dmem_wdata_o,
    input  dmem_rdata_i, dmem_ack_i
  );

  modport slave (
    input  dmem_req_o, dmem_addr_o, dmem_we_o, dmem_wdata_o,
    output dmem_rdata_i, dmem_ack_i
  );
endinterface

// File: rtl/dmem_lsu_ctrl.sv
// Load/store handshake controller: one registered req/ack transaction per
// memory op, stalls upstream while outstanding, bounded by a timeout.
module dmem_lsu_ctrl
  import simple_processor_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  exe_valid_i,
  input  func_t                 exe_func_i,
  input  logic [DATA_WIDTH-1:0] exe_addr_i,
  input  logic [DATA_WIDTH-1:0] exe_wdata_i,
  output logic                  stall_o,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  err_o,
  dmem_lsu_ctrl_if.master       dmem
);

  localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             mem_op;

  assign mem_op  = exe_valid_i && (exe_func_i == LOAD || exe_func_i == STORE);

  // Upstream holds while an op is being accepted or is outstanding.
  assign stall_o = (state == LSU_IDLE && mem_op) || (state == LSU_WAIT);

  // Transaction FSM; every DMEM-facing signal is a register.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state             <= LSU_IDLE;
      cnt               <= '0;
      dmem.dmem_req_o   <= 1'b0;
      dmem.dmem_we_o    <= 1'b0;
      dmem.dmem_addr_o  <= '0;
      dmem.dmem_wdata_o <= '0;
      rd_data_o         <= '0;
      rd_valid_o        <= 1'b0;
      err_o             <= 1'b0;
    end else begin
      // Result and error strobes are single-cycle pulses.
      rd_valid_o <= 1'b0;
      err_o      <= 1'b0;
      unique case (state)
        LSU_IDLE: begin
          if (mem_op) begin
            dmem.dmem_addr_o  <= exe_addr_i;
            dmem.dmem_wdata_o <= exe_wdata_i;
            dmem.dmem_we_o    <= (exe_func_i == STORE);
            dmem.dmem_req_o   <= 1'b1;
            cnt               <= '0;
            state             <= LSU_WAIT;
          end
        end
        LSU_WAIT: begin
          // Ack has priority over a coincident timeout.
          if (dmem.dmem_ack_i) begin
            dmem.dmem_req_o <= 1'b0;
            dmem.dmem_we_o  <= 1'b0;
            if (!dmem.dmem_we_o) begin
              rd_data_o  <= dmem.dmem_rdata_i;
              rd_valid_o <= 1'b1;
            end
            state <= LSU_RESP;
          end else if (cnt == CNT_MAX) begin
            dmem.dmem_req_o <= 1'b0;
            err_o           <= 1'b1;
            rd_data_o       <= '0;
            state           <= LSU_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LSU_RESP: state <= LSU_IDLE;
        default:  state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Directed bench for dmem_lsu_ctrl with a result scoreboard.
module tb_dmem_lsu_ctrl;
  import simple_processor_pkg::*;

  typedef struct {
    logic        err;
    logic        ld;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        exe_valid = 1'b0;
  func_t       exe_func = ADD;
  logic [31:0] exe_addr = '0;
  logic [31:0] exe_wdata = '0;
  logic        stall, rd_valid, err;
  logic [31:0] rd_data;
  logic [31:0] last_rd;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];

  dmem_lsu_ctrl_if dif();

  dmem_lsu_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i       (clk),
    .arst_i      (arst),
    .exe_valid_i (exe_valid),
    .exe_func_i  (exe_func),
    .exe_addr_i  (exe_addr),
    .exe_wdata_i (exe_wdata),
    .stall_o     (stall),
    .rd_valid_o  (rd_valid),
    .rd_data_o   (rd_data),
    .err_o       (err),
    .dmem        (dif.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every rd_valid/err pulse must match the next queued result.
  always @(negedge clk) begin
    if (!arst && (rd_valid || err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, err, rd_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_err", {31'd0, err}, {31'd0, e.err});
        chk("sb_rd_valid", {31'd0, rd_valid}, {31'd0, e.ld});
        chk("sb_rd_data", rd_data, e.data);
      end
    end
  end

  // One memory op; ack_at = WAIT cycle index carrying ack, 0 = never ack.
  task automatic run_op(input string tag, input func_t f, input logic [31:0] a,
                        input logic [31:0] wd, input int ack_at,
                        input logic [31:0] rdv, input int exp_req);
    int reqc = 0;
    int stc  = 0;
    exe_valid = 1'b1; exe_func = f; exe_addr = a; exe_wdata = wd;
    #1;
    if (stall) stc++;
    if (ack_at == 0) sb.push_back('{err: 1'b1, ld: 1'b0, data: 32'd0});
    @(posedge clk); #1;
    exe_valid = 1'b0; exe_func = ADD;
    for (int k = 1; k <= 40; k++) begin
      if (!dif.dmem_req_o) break;
      reqc++;
      if (stall) stc++;
      if (k == 1) begin
        chk({tag, "_addr"}, dif.dmem_addr_o, a);
        chk({tag, "_we"}, {31'd0, dif.dmem_we_o}, {31'd0, f == STORE});
        chk({tag, "_wdata"}, dif.dmem_wdata_o, wd);
      end
      if (k == ack_at) begin
        dif.dmem_ack_i = 1'b1;
        dif.dmem_rdata_i = rdv;
        if (f == LOAD) begin
          sb.push_back('{err: 1'b0, ld: 1'b1, data: rdv});
          last_rd = rdv;
        end
      end
      @(posedge clk); #1;
      dif.dmem_ack_i = 1'b0;
    end
    chk({tag, "_resp_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_resp_req"}, {31'd0, dif.dmem_req_o}, 32'd0);
    chk({tag, "_req_cycles"}, reqc, exp_req);
    chk({tag, "_stall_cycles"}, stc, exp_req + 1);
    @(posedge clk); #1;
  endtask

  initial begin
    dif.dmem_ack_i   = 1'b0;
    dif.dmem_rdata_i = '0;
    last_rd          = '0;
    #12;
    chk("rst_req", {31'd0, dif.dmem_req_o}, 32'd0);
    chk("rst_we", {31'd0, dif.dmem_we_o}, 32'd0);
    chk("rst_addr", dif.dmem_addr_o, 32'd0);
    chk("rst_wdata", dif.dmem_wdata_o, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_flags", {29'd0, stall, rd_valid, err}, 32'd0);
    @(posedge clk); #1;
    arst = 1'b0;
    @(posedge clk); #1;

    // 1: LOAD, ack on third WAIT cycle
    run_op("load", LOAD, 32'h40, 32'h0, 3, 32'hDEADBEEF, 3);
    // 2: STORE, ack in first WAIT cycle
    run_op("store", STORE, 32'h10, 32'h12345678, 1, 32'hAAAA5555, 1);
    chk("store_keeps_rd", rd_data, last_rd);
    // 3: no ack -> timeout after 16 request cycles
    run_op("tmo", LOAD, 32'h44, 32'h0, 0, 32'h0, 16);
    chk("tmo_idle_stall", {31'd0, stall}, 32'd0);
    chk("tmo_rd_data", rd_data, 32'd0);
    // 4: ack on the timeout cycle wins
    run_op("ack_tmo", LOAD, 32'h48, 32'h0, 16, 32'hCAFEF00D, 16);

    // 5: reset during WAIT of a LOAD
    exe_valid = 1'b1; exe_func = LOAD; exe_addr = 32'h80;
    @(posedge clk); #1;
    exe_valid = 1'b0; exe_func = ADD;
    chk("rstw_req_before", {31'd0, dif.dmem_req_o}, 32'd1);
    #2 arst = 1'b1;
    #1;
    chk("rstw_req_async", {31'd0, dif.dmem_req_o}, 32'd0);
    chk("rstw_stall", {31'd0, stall}, 32'd0);
    dif.dmem_ack_i = 1'b1; dif.dmem_rdata_i = 32'h55555555;
    @(posedge clk); #1;
    dif.dmem_ack_i = 1'b0;
    arst = 1'b0;
    last_rd = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rstw_no_rd", rd_data, 32'd0);
    run_op("rstw_next", LOAD, 32'h84, 32'h0, 1, 32'h01234567, 1);

    // 6: non-memory op plus a spurious ack in IDLE
    exe_valid = 1'b1; exe_func = ADD; exe_addr = 32'h90;
    dif.dmem_ack_i = 1'b1; dif.dmem_rdata_i = 32'hBADBAD00;
    #1;
    chk("alu_stall", {31'd0, stall}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("alu_req", {31'd0, dif.dmem_req_o}, 32'd0);
    chk("alu_stall2", {31'd0, stall}, 32'd0);
    chk("alu_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("alu_rd_data", rd_data, last_rd);
    exe_valid = 1'b0; dif.dmem_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #20000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_lsu_ctrl.md
Name: dmem_lsu_ctrl

Overview:
Load/store handshake controller directly downstream of the execution unit. It takes the memory operation the execution stage resolves (LOAD/STORE, address, store data) and runs a registered req/ack transaction with DMEM. It stalls the pipeline while the transaction is outstanding and returns load data for register-file writeback. A bounded timeout prevents a missing ack from hanging the core.

Parameters:
TIMEOUT_CYCLES, 16, maximum number of WAIT cycles without dmem_ack_i before abort; legal values are 2 or more.
DATA_WIDTH, from simple_processor_pkg (32), data and address width.

Ports:
clk_i  in  1  core clock
arst_i  in  1  asynchronous, active-high reset
exe_valid_i  in  1  execution stage presents an operation this cycle
exe_func_i  in  func_t  operation code; only LOAD and STORE are acted on
exe_addr_i  in  DATA_WIDTH  memory address (rs1 value)
exe_wdata_i  in  DATA_WIDTH  store data (rs2 value)
stall_o  out  1  upstream must hold its current operation
rd_valid_o  out  1  one-cycle pulse: rd_data_o holds completed load data
rd_data_o  out  DATA_WIDTH  load result for RF writeback
err_o  out  1  one-cycle pulse: transaction aborted on timeout
dmem_req_o  out  1  DMEM request
dmem_addr_o  out  DATA_WIDTH  DMEM address
dmem_we_o  out  1  1 = write (STORE), 0 = read
dmem_wdata_o  out  DATA_WIDTH  DMEM write data
dmem_rdata_i  in  DATA_WIDTH  DMEM read data, valid with ack
dmem_ack_i  in  1  DMEM transaction-complete strobe

Behaviour:
- Clock and reset: single clock clk_i. Reset arst_i is asynchronous and active-high.
- Reset values: state IDLE. All registered outputs are 0: dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, rd_data_o, rd_valid_o, err_o, and the timeout counter.
- DMEM outputs are driven only from registers; nothing combinational reaches the DMEM port.
- stall_o is combinational: (state==IDLE && mem_op) || state==WAIT, where mem_op = exe_valid_i && exe_func_i is LOAD or STORE.
- IDLE:
  - On mem_op, register exe_addr_i, exe_wdata_i, and we = (exe_func_i==STORE).
  - Set dmem_req_o=1, clear the counter, go to WAIT.
  - Non-memory or invalid operations cause no DMEM activity and stall_o=0.
- WAIT:
  - dmem_req_o, addr, we and wdata are held stable.
  - Counter increments every cycle that dmem_ack_i=0.
  - On dmem_ack_i=1:
    - dmem_req_o <= 0 and dmem_we_o <= 0; go to RESP.
    - For a LOAD: rd_data_o <= dmem_rdata_i and rd_valid_o <= 1.
    - For a STORE: rd_data_o is unchanged and rd_valid_o stays 0.
  - On timeout (counter == TIMEOUT_CYCLES-1 with no ack):
    - dmem_req_o <= 0, err_o <= 1, rd_data_o <= 0, rd_valid_o <= 0; go to RESP.
  - If ack arrives in the same cycle as the timeout, ack wins and err_o stays 0.
- RESP:
  - Lasts exactly one cycle, with stall_o=0 so upstream retires the operation.
  - rd_valid_o and err_o are high only in this cycle and clear on exit.
  - exe_valid_i is ignored here; next state is IDLE.
- Ack outside WAIT is ignored and the data is discarded.
- Latency: with ack in the first WAIT cycle, a memory operation takes 3 cycles.
  - Cycle 0: IDLE, stall high.
  - Cycle 1: WAIT, req high.
  - Cycle 2: RESP, rd_valid high.
- Back-to-back memory operations therefore issue at most one every 3 cycles.
- Reset mid-transaction: req drops immediately (asynchronously) and any pending load result is lost. DMEM must tolerate an abandoned request.
- Counter width is $clog2(TIMEOUT_CYCLES); no wrap can occur because the counter never exceeds TIMEOUT_CYCLES-1.

Decomposition:
- simple_processor_pkg gains:
  - lsu_state_t enum {LSU_IDLE, LSU_WAIT, LSU_RESP}.
  - LSU_TIMEOUT_DEFAULT = 16.
- DATA_WIDTH and func_t (LOAD, STORE) are reused from the package unchanged.
- The design is a single module. The timeout counter is small enough to stay inline; no sub-module.

Test Plan:
1. LOAD, ack after 2 WAIT cycles: exe_addr_i=0x40, dmem_rdata_i=0xDEADBEEF -> dmem_req_o high 3 cycles with addr 0x40 and we=0; rd_valid_o pulses once with rd_data_o=0xDEADBEEF; stall_o high 4 cycles, err_o=0.
2. STORE, ack in first WAIT cycle: addr 0x10, wdata 0x12345678 -> one request cycle with we=1 and wdata 0x12345678; rd_valid_o=0; stall_o high 2 cycles, low in RESP.
3. No ack, TIMEOUT_CYCLES=16 -> req high exactly 16 cycles, then err_o pulses, rd_data_o=0, rd_valid_o=0, state returns to IDLE.
4. Ack on timeout cycle 16 -> normal completion with err_o=0 and rd_valid_o=1 (LOAD).
5. arst_i asserted during WAIT of a LOAD -> dmem_req_o=0 immediately; no rd_valid_o after reset release; the next LOAD completes normally.
6. exe_func_i=ADD with exe_valid_i=1, plus a spurious dmem_ack_i in IDLE -> no req, stall_o=0, rd_valid_o=0, rd_data_o unchanged.
